// File: rtl/nnrv_mem.sv
// nnrv_mem: memory stage. ALU results pass to writeback in one cycle.
// Loads and stores are held in registers while a single-word RAM access runs.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_ex_*       : exec-stage result, load/store request, addr/data/mask/sign
//   o_ex_stall   : upstream must hold i_ex_* stable while high
//   o_ram_*      : RAM request, word address, write data, byte enables
//   i_ram_*      : RAM completion strobe and read word
//   o_wb_*       : registered writeback to the register file
module nnrv_mem #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_rd_en,
  input  logic [4:0]            i_ex_rd,
  input  logic [XLEN-1:0]       i_ex_rd_reg,
  input  logic                  i_ex_ram_rd_en,
  input  logic                  i_ex_ram_wr_en,
  input  logic [XLEN-1:0]       i_ex_ram_addr,
  input  logic [XLEN-1:0]       i_ex_ram_data,
  input  logic [3:0]            i_ex_ram_mask,
  input  logic                  i_ex_sign,
  output logic                  o_ex_stall,
  output logic                  o_ram_req,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [XLEN-1:0]       o_ram_wdata,
  output logic [3:0]            o_ram_be,
  input  logic                  i_ram_ack,
  input  logic [XLEN-1:0]       i_ram_rdata,
  output logic                  o_wb_rd_en,
  output logic [4:0]            o_wb_rd,
  output logic [XLEN-1:0]       o_wb_rd_reg
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH+1:0] addr_q;
  logic [XLEN-1:0]       data_q;
  logic [3:0]            mask_q;
  logic                  sign_q;
  logic [4:0]            rd_q;
  logic                  rd_en_q;
  logic                  we_q;

  logic                  wb_en_q;
  logic [4:0]            wb_rd_q;
  logic [XLEN-1:0]       wb_val_q;

  logic                  req_in;
  logic [1:0]            off;
  logic [XLEN-1:0]       sh;
  logic [3:0]            size_m;
  logic [XLEN-1:0]       ld_val;

  // Only the word-address and lane bits of the byte address are kept.
  logic                  unused_addr;
  assign unused_addr = ^i_ex_ram_addr[XLEN-1:ADDR_WIDTH+2];

  assign req_in = i_ex_ram_rd_en | i_ex_ram_wr_en;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_in)    state_d = ACCESS;
      ACCESS:  if (i_ram_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM side is driven only from the holding registers.
  always_comb begin
    o_ram_req  = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_be   = 4'b0000;
    o_ex_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ex_stall = req_in;
      end
      ACCESS: begin
        o_ram_req  = 1'b1;
        o_ram_we   = we_q;
        o_ram_be   = we_q ? mask_q : 4'b0000;
        o_ex_stall = ~i_ram_ack;
      end
      default: ;
    endcase
  end

  assign o_ram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign o_ram_wdata = data_q;

  // Load extraction: the lane mask shifted down to bit 0 gives the size.
  assign off    = addr_q[1:0];
  assign sh     = i_ram_rdata >> {off, 3'b000};
  assign size_m = mask_q >> off;

  always_comb begin
    ld_val = sh;
    case (size_m)
      4'b0001: ld_val = {{(XLEN-8){sign_q & sh[7]}}, sh[7:0]};
      4'b0011: ld_val = {{(XLEN-16){sign_q & sh[15]}}, sh[15:0]};
      4'b1111: ld_val = sh;
      default: ld_val = sh;
    endcase
  end

  // Holding registers and writeback
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      sign_q   <= 1'b0;
      rd_q     <= '0;
      rd_en_q  <= 1'b0;
      we_q     <= 1'b0;
      wb_en_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_val_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_in) begin
            addr_q  <= i_ex_ram_addr[ADDR_WIDTH+1:0];
            data_q  <= i_ex_ram_data;
            mask_q  <= i_ex_ram_mask;
            sign_q  <= i_ex_sign;
            rd_q    <= i_ex_rd;
            rd_en_q <= i_ex_rd_en;
            // A combined load+store request is a store.
            we_q    <= i_ex_ram_wr_en;
            wb_en_q <= 1'b0;
          end else begin
            wb_en_q  <= i_ex_rd_en;
            wb_rd_q  <= i_ex_rd;
            wb_val_q <= i_ex_rd_reg;
          end
        end
        ACCESS: begin
          if (i_ram_ack && !we_q) begin
            wb_en_q  <= rd_en_q;
            wb_rd_q  <= rd_q;
            wb_val_q <= ld_val;
          end else begin
            wb_en_q <= 1'b0;
          end
        end
        default: wb_en_q <= 1'b0;
      endcase
    end
  end

  assign o_wb_rd_en  = wb_en_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_rd_reg = wb_val_q;

endmodule

// File: tb/tb_nnrv_mem.sv
// tb_nnrv_mem: random + directed stimulus for nnrv_mem.
// Expected writebacks and RAM transactions are queued at issue time.
module tb_nnrv_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst;
  logic        i_ex_rd_en;
  logic [4:0]  i_ex_rd;
  logic [31:0] i_ex_rd_reg;
  logic        i_ex_ram_rd_en;
  logic        i_ex_ram_wr_en;
  logic [31:0] i_ex_ram_addr;
  logic [31:0] i_ex_ram_data;
  logic [3:0]  i_ex_ram_mask;
  logic        i_ex_sign;
  logic        o_ex_stall;
  logic        o_ram_req;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [3:0]  o_ram_be;
  logic        i_ram_ack;
  logic [31:0] i_ram_rdata;
  logic        o_wb_rd_en;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_rd_reg;

  nnrv_mem #(.XLEN(32), .ADDR_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_ex_rd_en     (i_ex_rd_en),
    .i_ex_rd        (i_ex_rd),
    .i_ex_rd_reg    (i_ex_rd_reg),
    .i_ex_ram_rd_en (i_ex_ram_rd_en),
    .i_ex_ram_wr_en (i_ex_ram_wr_en),
    .i_ex_ram_addr  (i_ex_ram_addr),
    .i_ex_ram_data  (i_ex_ram_data),
    .i_ex_ram_mask  (i_ex_ram_mask),
    .i_ex_sign      (i_ex_sign),
    .o_ex_stall     (o_ex_stall),
    .o_ram_req      (o_ram_req),
    .o_ram_we       (o_ram_we),
    .o_ram_addr     (o_ram_addr),
    .o_ram_wdata    (o_ram_wdata),
    .o_ram_be       (o_ram_be),
    .i_ram_ack      (i_ram_ack),
    .i_ram_rdata    (i_ram_rdata),
    .o_wb_rd_en     (o_wb_rd_en),
    .o_wb_rd        (o_wb_rd),
    .o_wb_rd_reg    (o_wb_rd_reg)
  );

  typedef struct {
    int          kind;
    bit          rd_en;
    logic [4:0]  rd;
    logic [31:0] rd_reg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    bit          sign;
    int          dly;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_t;

  wb_t         wbq[$];
  ram_t        ramq[$];
  logic [31:0] ram_mem[256];
  logic [31:0] ref_mem[256];

  int          total = 0;
  int          bad = 0;
  int          next_dly = 0;
  bit          rsp_en = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw,
                                        logic [3:0] be);
    logic [31:0] r;
    logic [31:0] lane;
    r = old;
    for (int j = 0; j < 4; j++) begin
      lane = 32'hFF << (8 * j);
      if (be[j]) r = (r & ~lane) | (nw & lane);
    end
    return r;
  endfunction

  // Load value from the word, byte offset, lane mask and sign flag.
  function automatic logic [31:0] ld_ref(logic [31:0] word, logic [31:0] addr,
                                         logic [3:0] mask, bit sign);
    int unsigned off;
    logic [31:0] sh;
    logic [31:0] m;
    logic [31:0] v;
    off = addr % 4;
    sh  = word >> (8 * off);
    m   = (32'(mask) >> off) & 32'hF;
    if (m == 1) begin
      v = sh & 32'hFF;
      if (sign && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (m == 3) begin
      v = sh & 32'hFFFF;
      if (sign && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  // RAM responder: ack after next_dly cycles of request; noise in idle.
  initial begin
    int k;
    k = 0;
    i_ram_ack = 1'b0;
    i_ram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rsp_en) begin
        i_ram_ack = man_ack;
        i_ram_rdata = man_rdata;
      end else if (o_ram_req) begin
        if (k == next_dly) begin
          i_ram_ack = 1'b1;
          i_ram_rdata = ram_mem[o_ram_addr];
        end else begin
          i_ram_ack = 1'b0;
          i_ram_rdata = $urandom;
        end
        k++;
      end else begin
        k = 0;
        i_ram_ack = ($urandom_range(0, 3) == 0);
        i_ram_rdata = $urandom;
      end
    end
  end

  // Monitor: compares every writeback and every RAM request cycle.
  initial begin
    wb_t  e;
    ram_t r;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_wb_rd_en) begin
          if (wbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d val=%h want none",
                     o_wb_rd, o_wb_rd_reg);
          end else begin
            e = wbq.pop_front();
            chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
            chk("wb_val", o_wb_rd_reg, e.val);
          end
        end
        if (o_ram_req) begin
          if (ramq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ram_unexpected: got addr=%h want none", o_ram_addr);
          end else begin
            r = ramq[0];
            chk("ram_addr", 32'(o_ram_addr), 32'(r.addr));
            chk("ram_we", 32'(o_ram_we), 32'(r.we));
            chk("ram_be", 32'(o_ram_be), 32'(r.be));
            if (r.we) chk("ram_wdata", o_ram_wdata, r.wdata);
            if (i_ram_ack) begin
              if (o_ram_we)
                ram_mem[o_ram_addr] = merge(ram_mem[o_ram_addr],
                                            o_ram_wdata, o_ram_be);
              void'(ramq.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic run_instr(instr_t in);
    bit   rdn;
    bit   wrn;
    int   stalls;
    int   cyc;
    int   exp_st;
    logic [7:0] w;
    rdn = (in.kind == 1) || (in.kind == 3);
    wrn = (in.kind == 2) || (in.kind == 3);
    i_ex_rd_en     = in.rd_en;
    i_ex_rd        = in.rd;
    i_ex_rd_reg    = in.rd_reg;
    i_ex_ram_rd_en = rdn;
    i_ex_ram_wr_en = wrn;
    i_ex_ram_addr  = in.addr;
    i_ex_ram_data  = in.data;
    i_ex_ram_mask  = in.mask;
    i_ex_sign      = in.sign;
    next_dly       = in.dly;
    w = 8'((in.addr >> 2) & 32'hFF);
    if (wrn) begin
      ramq.push_back('{w, 1'b1, in.mask, in.data});
      ref_mem[w] = merge(ref_mem[w], in.data, in.mask);
    end else if (rdn) begin
      ramq.push_back('{w, 1'b0, 4'b0000, 32'h0});
      if (in.rd_en)
        wbq.push_back('{in.rd, ld_ref(ref_mem[w], in.addr, in.mask, in.sign)});
    end else if (in.rd_en) begin
      wbq.push_back('{in.rd, in.rd_reg});
    end
    exp_st = (rdn || wrn) ? 1 + in.dly : 0;
    stalls = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!o_ex_stall) break;
      stalls++;
      cyc++;
      if (cyc > 60) begin
        total++;
        bad++;
        $display("FAIL stall_timeout: got %0d cycles want %0d", cyc, exp_st);
        break;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_st));
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(int kind, bit rd_en, logic [4:0] rd,
                                logic [31:0] rd_reg, logic [31:0] addr,
                                logic [31:0] data, logic [3:0] mask,
                                bit sign, int dly);
    instr_t t;
    t.kind = kind;
    t.rd_en = rd_en;
    t.rd = rd;
    t.rd_reg = rd_reg;
    t.addr = addr;
    t.data = data;
    t.mask = mask;
    t.sign = sign;
    t.dly = dly;
    return t;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    int unsigned off;
    int unsigned p;
    logic [31:0] pat;
    t.kind   = int'($urandom_range(0, 3));
    t.rd_en  = ($urandom_range(0, 3) != 0);
    t.rd     = 5'($urandom);
    t.rd_reg = $urandom;
    t.addr   = $urandom;
    t.data   = $urandom;
    t.sign   = 1'($urandom);
    t.dly    = int'($urandom_range(0, 4));
    off = t.addr % 4;
    p = $urandom_range(0, 3);
    if (p == 0)      pat = 32'h1;
    else if (p == 1) pat = 32'h3;
    else if (p == 2) pat = 32'hF;
    else             pat = $urandom_range(0, 15);
    t.mask = 4'((pat << off) & 32'hF);
    return t;
  endfunction

  initial begin
    logic [31:0] v;
    i_rst = 1'b1;
    i_ex_rd_en = 1'b0;
    i_ex_rd = '0;
    i_ex_rd_reg = '0;
    i_ex_ram_rd_en = 1'b0;
    i_ex_ram_wr_en = 1'b0;
    i_ex_ram_addr = '0;
    i_ex_ram_data = '0;
    i_ex_ram_mask = '0;
    i_ex_sign = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ram_mem[4] = 32'h80AB_CDEF;
    ref_mem[4] = 32'h80AB_CDEF;
    ram_mem[0] = 32'hF00D_1234;
    ref_mem[0] = 32'hF00D_1234;

    #1;
    chk("rst_req", 32'(o_ram_req), 32'h0);
    chk("rst_we", 32'(o_ram_we), 32'h0);
    chk("rst_be", 32'(o_ram_be), 32'h0);
    chk("rst_addr", 32'(o_ram_addr), 32'h0);
    chk("rst_wdata", o_ram_wdata, 32'h0);
    chk("rst_wb_en", 32'(o_wb_rd_en), 32'h0);
    chk("rst_wb_rd", 32'(o_wb_rd), 32'h0);
    chk("rst_wb_val", o_wb_rd_reg, 32'h0);
    chk("rst_stall", 32'(o_ex_stall), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr(mk(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0));
    chk("alu_rd", 32'(o_wb_rd), 32'd5);
    chk("alu_val", o_wb_rd_reg, 32'h1234);
    run_instr(mk(1, 1, 7, 0, 32'h13, 0, 4'b1000, 1, 1));
    chk("lb_val", o_wb_rd_reg, 32'hFFFF_FF80);
    chk("lb_en", 32'(o_wb_rd_en), 32'h1);
    run_instr(mk(1, 1, 3, 0, 32'h2, 0, 4'b1100, 0, 0));
    chk("lhu_val", o_wb_rd_reg, 32'h0000_F00D);
    run_instr(mk(0, 1, 11, 32'hCAFE, 0, 0, 0, 0, 0));
    run_instr(mk(2, 0, 0, 0, 32'h8, 32'hDEAD_BEEF, 4'b1111, 0, 3));
    chk("sw_wb_en", 32'(o_wb_rd_en), 32'h0);
    run_instr(mk(3, 1, 4, 0, 32'h20, 32'h0BAD_F00D, 4'b1111, 0, 2));
    chk("both_wb_en", 32'(o_wb_rd_en), 32'h0);
    run_instr(mk(1, 1, 6, 0, 32'h8, 0, 4'b0110, 1, 0));

    for (int n = 0; n < 300; n++) run_instr(rnd_instr());

    i_ex_rd_en = 1'b0;
    i_ex_ram_rd_en = 1'b0;
    i_ex_ram_wr_en = 1'b0;
    @(negedge clk);
    chk("wbq_drained", 32'(wbq.size()), 32'h0);
    chk("ramq_drained", 32'(ramq.size()), 32'h0);

    // Reset in the middle of an access, then a stray ack.
    rsp_en = 1'b0;
    man_ack = 1'b0;
    @(posedge clk);
    #1;
    i_ex_rd_en = 1'b1;
    i_ex_rd = 5'd9;
    i_ex_ram_rd_en = 1'b1;
    i_ex_ram_addr = 32'h40;
    i_ex_ram_mask = 4'b1111;
    ramq.push_back('{8'h10, 1'b0, 4'b0000, 32'h0});
    @(posedge clk);
    #1;
    chk("mid_req", 32'(o_ram_req), 32'h1);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(o_ram_req), 32'h0);
    chk("mid_rst_addr", 32'(o_ram_addr), 32'h0);
    chk("mid_rst_wb_en", 32'(o_wb_rd_en), 32'h0);
    ramq.delete();
    i_ex_rd_en = 1'b0;
    i_ex_ram_rd_en = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    man_ack = 1'b1;
    man_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_wb_en", 32'(o_wb_rd_en), 32'h0);
    chk("stray_req", 32'(o_ram_req), 32'h0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
